// File: rtl/alarm_scheduler.sv
// Home-alarm controller: arbitrates keypad/WiFi commands and perimeter/tamper sensors,
// sequences exit/entry/siren delays on a 1 Hz tick and raises uplink notifications.
module alarm_scheduler #(
    parameter int EXIT_DELAY  = 30,
    parameter int ENTRY_DELAY = 15,
    parameter int SIREN_TIME  = 180
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       key_valid,
    input  logic [4:0] key_cmd,
    input  logic       wifi_valid,
    input  logic [4:0] wifi_cmd,
    output logic       key_ready,
    output logic       wifi_ready,
    input  logic       ultras_hub,
    input  logic       ultras_else,
    output logic       notify_valid,
    output logic [1:0] notify_code,
    input  logic       notify_ack,
    output logic       siren,
    output logic       lock,
    output logic       armed,
    output logic [5:0] LEDS,
    output logic [7:0] remaining,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        S_DISARMED   = 3'd0,
        S_EXIT_WAIT  = 3'd1,
        S_ARMED      = 3'd2,
        S_ENTRY_WAIT = 3'd3,
        S_ALARM      = 3'd4,
        S_PANIC      = 3'd5
    } state_t;

    localparam int EXIT_EFF  = (EXIT_DELAY  == 0) ? 1 : EXIT_DELAY;
    localparam int ENTRY_EFF = (ENTRY_DELAY == 0) ? 1 : ENTRY_DELAY;
    localparam int SIREN_EFF = (SIREN_TIME  == 0) ? 1 : SIREN_TIME;
    localparam logic [7:0] EXIT_LD  = 8'(EXIT_EFF);
    localparam logic [7:0] ENTRY_LD = 8'(ENTRY_EFF);
    localparam logic [7:0] SIREN_LD = 8'(SIREN_EFF);

    localparam logic [4:0] CMD_DISARM = 5'h0A;
    localparam logic [4:0] CMD_ARM    = 5'h0B;
    localparam logic [4:0] CMD_PANIC  = 5'h0E;

    state_t     state;
    state_t     state_next;
    logic [7:0] counter;
    logic [4:0] cmd;
    logic       cmd_take;
    logic       do_disarm;
    logic       do_panic;
    logic       do_arm;
    logic       expiry;
    logic       entering;
    logic [7:0] load_value;

    // Handshake: a request is consumed on any cycle where its valid and ready are both high;
    // ready depends only on the valids (keypad wins), so at most one command lands per cycle.
    assign key_ready  = key_valid;
    assign wifi_ready = wifi_valid & ~key_valid;

    assign cmd_take  = (key_valid | wifi_valid) & ~reset;
    assign cmd       = key_valid ? key_cmd : wifi_cmd;
    assign do_disarm = cmd_take && (cmd == CMD_DISARM);
    assign do_panic  = cmd_take && (cmd == CMD_PANIC);
    assign do_arm    = cmd_take && (cmd == CMD_ARM);
    assign expiry    = tick && (counter == 8'd1);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_DISARMED;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, events checked in priority order
    always_comb begin
        state_next = state;
        unique case (state)
            S_DISARMED: begin
                if (do_panic)    state_next = S_PANIC;
                else if (do_arm) state_next = S_EXIT_WAIT;
            end
            S_EXIT_WAIT: begin
                if (do_disarm)     state_next = S_DISARMED;
                else if (do_panic) state_next = S_PANIC;
                else if (expiry)   state_next = S_ARMED;
            end
            S_ARMED: begin
                if (do_disarm)        state_next = S_DISARMED;
                else if (do_panic)    state_next = S_PANIC;
                else if (ultras_hub)  state_next = S_ALARM;
                else if (ultras_else) state_next = S_ENTRY_WAIT;
            end
            S_ENTRY_WAIT: begin
                if (do_disarm)       state_next = S_DISARMED;
                else if (do_panic)   state_next = S_PANIC;
                else if (ultras_hub) state_next = S_ALARM;
                else if (expiry)     state_next = S_ALARM;
            end
            S_ALARM: begin
                if (do_disarm)     state_next = S_DISARMED;
                else if (do_panic) state_next = S_PANIC;
                else if (expiry)   state_next = S_ARMED;
            end
            S_PANIC: begin
                if (do_disarm) state_next = S_DISARMED;
            end
            default: state_next = S_DISARMED;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        LEDS      = 6'b000001 << state;
        siren     = (state == S_ALARM) || (state == S_PANIC);
        lock      = (state == S_PANIC);
        armed     = (state == S_ARMED) || (state == S_ENTRY_WAIT) || (state == S_ALARM);
        fsm_state = state;
    end

    assign entering = (state_next != state);

    always_comb begin
        load_value = 8'd0;
        case (state_next)
            S_EXIT_WAIT:  load_value = EXIT_LD;
            S_ENTRY_WAIT: load_value = ENTRY_LD;
            S_ALARM:      load_value = SIREN_LD;
            default:      load_value = 8'd0;
        endcase
    end

    // Delay counter: reloaded on every state change, so expiry (1 -> transition) also clears it
    always_ff @(posedge clock) begin
        if (reset) begin
            counter <= 8'd0;
        end else if (entering) begin
            counter <= load_value;
        end else if (tick && counter > 8'd1) begin
            counter <= counter - 8'd1;
        end
    end

    // A fresh event wins over a same-cycle ack so it is never lost
    always_ff @(posedge clock) begin
        if (reset) begin
            notify_valid <= 1'b0;
            notify_code  <= 2'd0;
        end else if (entering && (state_next == S_ALARM || state_next == S_PANIC)) begin
            notify_valid <= 1'b1;
            notify_code  <= (state_next == S_PANIC) ? 2'd3 : 2'd2;
        end else if (notify_ack && notify_valid) begin
            notify_valid <= 1'b0;
        end
    end

    assign remaining = counter;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler: arm/entry/alarm sequencing, command arbitration,
// event priority, notification overwrite and reset abandonment, default delays.
module tb_alarm_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick;
    logic       key_valid;
    logic [4:0] key_cmd;
    logic       wifi_valid;
    logic [4:0] wifi_cmd;
    logic       key_ready;
    logic       wifi_ready;
    logic       ultras_hub;
    logic       ultras_else;
    logic       notify_valid;
    logic [1:0] notify_code;
    logic       notify_ack;
    logic       siren;
    logic       lock;
    logic       armed;
    logic [5:0] LEDS;
    logic [7:0] remaining;
    logic [2:0] fsm_state;

    int checks   = 0;
    int failures = 0;

    alarm_scheduler dut (
        .clock(clock), .reset(reset), .tick(tick),
        .key_valid(key_valid), .key_cmd(key_cmd),
        .wifi_valid(wifi_valid), .wifi_cmd(wifi_cmd),
        .key_ready(key_ready), .wifi_ready(wifi_ready),
        .ultras_hub(ultras_hub), .ultras_else(ultras_else),
        .notify_valid(notify_valid), .notify_code(notify_code), .notify_ack(notify_ack),
        .siren(siren), .lock(lock), .armed(armed),
        .LEDS(LEDS), .remaining(remaining), .fsm_state(fsm_state)
    );

    // Clock and reset block
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge, outputs sampled there too
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
    endtask

    task automatic key_send(input logic [4:0] c);
        key_valid = 1'b1;
        key_cmd   = c;
        step();
        key_valid = 1'b0;
    endtask

    task automatic wifi_send(input logic [4:0] c);
        wifi_valid = 1'b1;
        wifi_cmd   = c;
        step();
        wifi_valid = 1'b0;
    endtask

    task automatic ack_pulse();
        notify_ack = 1'b1;
        step();
        notify_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0;
        key_valid = 1'b0; key_cmd = 5'd0; wifi_valid = 1'b0; wifi_cmd = 5'd0;
        ultras_hub = 1'b0; ultras_else = 1'b0; notify_ack = 1'b0;

        // Readies follow the valids during reset; the command is discarded
        key_valid = 1'b1; key_cmd = 5'h0B; wifi_valid = 1'b1; wifi_cmd = 5'h0E;
        #1;
        check("rst_key_ready", 32'(key_ready), 32'd1);
        check("rst_wifi_ready", 32'(wifi_ready), 32'd0);
        step(); step();
        key_valid = 1'b0; wifi_valid = 1'b0;
        reset = 1'b0;
        step();
        check("rst_leds", 32'(LEDS), 32'h01);
        check("rst_remaining", 32'(remaining), 32'd0);
        check("rst_outs", 32'({siren, lock, armed}), 32'd0);
        check("rst_notify", 32'({notify_valid, notify_code}), 32'd0);

        // Unknown code accepted and ignored; ack without pending ignored
        key_valid = 1'b1; key_cmd = 5'h03;
        #1 check("unk_ready", 32'(key_ready), 32'd1);
        step(); key_valid = 1'b0;
        check("unk_leds", 32'(LEDS), 32'h01);
        ack_pulse();
        check("stray_ack", 32'(notify_valid), 32'd0);

        // Arm: exit delay of 30 ticks, ARM and sensors ignored meanwhile
        key_send(5'h0B);
        check("arm_leds", 32'(LEDS), 32'h02);
        check("arm_remaining", 32'(remaining), 32'd30);
        tick_n(10);
        check("exit_rem20", 32'(remaining), 32'd20);
        key_send(5'h0B);
        check("exit_rearm_ignored", 32'({LEDS, remaining}), 32'({6'h02, 8'd20}));
        ultras_hub = 1'b1; ultras_else = 1'b1; step(); ultras_hub = 1'b0; ultras_else = 1'b0;
        check("exit_sensor_ignored", 32'(LEDS), 32'h02);
        tick_n(19);
        check("exit_rem1", 32'({LEDS, remaining}), 32'({6'h02, 8'd1}));
        tick_n(1);
        check("armed_leds", 32'(LEDS), 32'h04);
        check("armed_remaining", 32'(remaining), 32'd0);
        check("armed_outs", 32'({siren, lock, armed}), 32'b001);

        // Entry: perimeter trip, 15 ticks to ALARM, 180 ticks back to ARMED
        ultras_else = 1'b1; step(); ultras_else = 1'b0;
        check("entry_leds", 32'({LEDS, remaining}), 32'({6'h08, 8'd15}));
        ultras_else = 1'b1; step(); ultras_else = 1'b0;
        check("entry_else_ignored", 32'({LEDS, remaining}), 32'({6'h08, 8'd15}));
        tick_n(14);
        check("entry_rem1", 32'({LEDS, remaining}), 32'({6'h08, 8'd1}));
        check("entry_no_notify", 32'(notify_valid), 32'd0);
        tick_n(1);
        check("alarm_leds", 32'({LEDS, remaining}), 32'({6'h10, 8'd180}));
        check("alarm_outs", 32'({siren, lock, armed}), 32'b101);
        check("alarm_notify", 32'({notify_valid, notify_code}), 32'b110);
        ack_pulse();
        check("alarm_acked", 32'(notify_valid), 32'd0);
        tick_n(179);
        check("alarm_rem1", 32'({LEDS, remaining}), 32'({6'h10, 8'd1}));
        tick_n(1);
        check("rearm_leds", 32'({LEDS, remaining}), 32'({6'h04, 8'd0}));
        check("rearm_siren", 32'(siren), 32'd0);

        // Hub and perimeter together go straight to ALARM
        ultras_hub = 1'b1; ultras_else = 1'b1; step(); ultras_hub = 1'b0; ultras_else = 1'b0;
        check("hub_prio_leds", 32'({LEDS, remaining}), 32'({6'h10, 8'd180}));
        check("hub_notify", 32'({notify_valid, notify_code}), 32'b110);

        // Overwrite: PANIC arrives with an ack in the same cycle
        wifi_valid = 1'b1; wifi_cmd = 5'h0E; notify_ack = 1'b1;
        #1 check("ovr_wifi_ready", 32'(wifi_ready), 32'd1);
        step(); wifi_valid = 1'b0; notify_ack = 1'b0;
        check("panic_leds", 32'({LEDS, remaining}), 32'({6'h20, 8'd0}));
        check("panic_outs", 32'({siren, lock, armed}), 32'b110);
        check("ovr_notify", 32'({notify_valid, notify_code}), 32'b111);

        // PANIC ignores ARM, ticks and sensors
        wifi_send(5'h0B);
        tick_n(3);
        ultras_hub = 1'b1; step(); ultras_hub = 1'b0;
        check("panic_stays", 32'({LEDS, lock}), 32'({6'h20, 1'b1}));

        // Disarm keeps a pending notification
        key_send(5'h0A);
        check("disarm_leds", 32'({LEDS, siren, lock}), 32'({6'h01, 2'b00}));
        check("disarm_keeps_notify", 32'({notify_valid, notify_code}), 32'b111);
        ack_pulse();
        check("panic_acked", 32'(notify_valid), 32'd0);

        // Arbitration in ALARM: keypad DISARM beats WiFi PANIC
        key_send(5'h0B);
        tick_n(30);
        ultras_hub = 1'b1; step(); ultras_hub = 1'b0;
        check("arb_in_alarm", 32'(LEDS), 32'h10);
        key_valid = 1'b1; key_cmd = 5'h0A; wifi_valid = 1'b1; wifi_cmd = 5'h0E;
        #1 check("arb_readies", 32'({key_ready, wifi_ready}), 32'b10);
        step(); key_valid = 1'b0; wifi_valid = 1'b0;
        check("arb_disarmed", 32'({LEDS, remaining, siren}), 32'({6'h01, 8'd0, 1'b0}));
        check("arb_notify", 32'({notify_valid, notify_code}), 32'b110);

        // Reset mid entry delay abandons the timer and the pending notification
        key_send(5'h0B);
        tick_n(30);
        ultras_else = 1'b1; step(); ultras_else = 1'b0;
        tick_n(8);
        check("pre_rst_entry", 32'({LEDS, remaining}), 32'({6'h08, 8'd7}));
        reset = 1'b1; step(); reset = 1'b0;
        check("mid_rst_leds", 32'({LEDS, remaining}), 32'({6'h01, 8'd0}));
        check("mid_rst_notify", 32'({notify_valid, notify_code}), 32'd0);
        tick_n(2);
        check("post_rst_idle", 32'({LEDS, armed}), 32'({6'h01, 1'b0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
